// File: rtl/vc_fwd_event_logger_pkg.sv
// vc_fwd_event_logger_pkg: link/record layout macros, shared widths and the tile-window compare helper

// Simplified manycore fwd packet: dst_x in the LSBs, addr in the MSBs
`define DECLARE_VC_LINK_PACKET_S(a,d,x,y) \
    typedef struct packed { \
        logic [(a)-1:0] addr; \
        logic [(d)-1:0] data; \
        logic [(y)-1:0] src_y; \
        logic [(x)-1:0] src_x; \
        logic [(y)-1:0] dst_y; \
        logic [(x)-1:0] dst_x; \
    } vc_link_packet_s

`define VC_LINK_PACKET_WIDTH(a,d,x,y) ((a)+(d)+2*(x)+2*(y))

// Fwd channel of one link direction: valid, packet, ready travelling the other way
`define DECLARE_VC_LINK_SIF_S(a,d,x,y) \
    typedef struct packed { \
        logic fwd_v; \
        vc_link_packet_s fwd_data; \
        logic fwd_ready_and_rev; \
    } vc_link_sif_s

`define VC_LINK_SIF_WIDTH(a,d,x,y) (`VC_LINK_PACKET_WIDTH(a,d,x,y)+2)

// Trace record, timestamp in the MSBs
`define DECLARE_VC_FWD_EVENT_S(x,y) \
    typedef struct packed { \
        logic [31:0] ctr; \
        logic [(x)-1:0] src_x; \
        logic [(y)-1:0] src_y; \
        logic [(x)-1:0] dst_x; \
        logic [(y)-1:0] dst_y; \
    } vc_fwd_event_s

`define VC_FWD_EVENT_WIDTH(x,y) (32+2*(x)+2*(y))

package vc_fwd_event_logger_pkg;

    localparam int ctr_width_gp = 32;

    // True when v lies in [lo, 2*lo); upper bound is strict
    function automatic logic in_window(input logic [31:0] v, input logic [31:0] lo);
        return (v >= lo) && (v < (lo << 1));
    endfunction

endpackage

// File: rtl/vc_fwd_event_fifo.sv
// vc_fwd_event_fifo: 1r1w record FIFO, extra pointer MSB separates full from empty

module vc_fwd_event_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 8,
    localparam int lg_lp  = $clog2(els_p),
    localparam int ptr_lp = lg_lp + 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_q [els_p];
    logic [ptr_lp-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic               empty, full, enq, deq;

    assign empty   = rd_ptr_q == wr_ptr_q;
    assign full    = (rd_ptr_q[lg_lp] != wr_ptr_q[lg_lp]) && (rd_ptr_q[lg_lp-1:0] == wr_ptr_q[lg_lp-1:0]);
    assign deq     = yumi_i & ~empty;
    // A same-cycle pop frees the slot the push lands in, so full does not block it
    assign ready_o = ~full | deq;
    assign enq     = v_i & ready_o;
    assign v_o     = ~empty;
    assign data_o  = mem_q[rd_ptr_q[lg_lp-1:0]];

    // Pointer advance, wraps naturally modulo 2*els_p
    always_comb begin
        rd_ptr_d = rd_ptr_q + ptr_lp'(deq);
        wr_ptr_d = wr_ptr_q + ptr_lp'(enq);
    end

    // Pointer registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Storage, deliberately unreset
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q[lg_lp-1:0]] <= data_i;
    end

    yumi_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i) !(yumi_i && empty));

endmodule

// File: rtl/vc_fwd_event_logger.sv
// vc_fwd_event_logger: timestamps fwd acceptances from a tile window into a drainable trace FIFO

module vc_fwd_event_logger
    import vc_fwd_event_logger_pkg::*;
#(
    parameter int link_addr_width_p = 16,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 5,
    parameter int num_tiles_x_p     = 4,
    parameter int num_tiles_y_p     = 4,
    parameter int els_p             = 8,
    parameter int drop_ctr_width_p  = 16,
    localparam int link_sif_width_lp = `VC_LINK_SIF_WIDTH(link_addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
    localparam int rec_width_lp      = `VC_FWD_EVENT_WIDTH(x_cord_width_p, y_cord_width_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [link_sif_width_lp-1:0] link_sif_i,
    input  logic [link_sif_width_lp-1:0] link_sif_o,
    input  logic [ctr_width_gp-1:0]      global_ctr_i,
    input  logic                         en_i,
    input  logic                         clear_i,
    output logic                         v_o,
    output logic [rec_width_lp-1:0]      data_o,
    input  logic                         yumi_i,
    output logic [drop_ctr_width_p-1:0]  drop_count_o,
    output logic                         overflow_o
);

    `DECLARE_VC_LINK_PACKET_S(link_addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
    `DECLARE_VC_LINK_SIF_S(link_addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
    `DECLARE_VC_FWD_EVENT_S(x_cord_width_p, y_cord_width_p);

    vc_link_sif_s               link_in, link_out;
    vc_link_packet_s            fwd_pkt;
    vc_fwd_event_s              rec;
    logic                       capture, fifo_ready, drop;
    logic [drop_ctr_width_p-1:0] drop_count_q, drop_count_d;
    logic                       overflow_q, overflow_d;
    logic                       unused_link;

    assign link_in  = link_sif_i;
    assign link_out = link_sif_o;
    assign fwd_pkt  = link_in.fwd_data;

    // The logger only snoops: request side from the inbound link, handshake from the vcache's ready
    assign unused_link = ^{link_in.fwd_ready_and_rev, link_out.fwd_v, link_out.fwd_data, fwd_pkt.addr, fwd_pkt.data};

    // Capture on an accepted fwd packet whose source sits inside the window
    always_comb begin
        capture   = en_i & link_in.fwd_v & link_out.fwd_ready_and_rev
                  & in_window(32'(fwd_pkt.src_x), 32'(num_tiles_x_p))
                  & in_window(32'(fwd_pkt.src_y), 32'(num_tiles_y_p));
        rec.ctr   = global_ctr_i;
        rec.src_x = fwd_pkt.src_x;
        rec.src_y = fwd_pkt.src_y;
        rec.dst_x = fwd_pkt.dst_x;
        rec.dst_y = fwd_pkt.dst_y;
    end

    vc_fwd_event_fifo #(
        .width_p (rec_width_lp),
        .els_p   (els_p)
    ) fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (capture),
        .ready_o   (fifo_ready),
        .data_i    (rec),
        .v_o       (v_o),
        .data_o    (data_o),
        .yumi_i    (yumi_i)
    );

    assign drop = capture & ~fifo_ready;

    // Saturating drop count and sticky flag; a same-cycle drop survives a clear
    always_comb begin
        drop_count_d = clear_i ? drop_ctr_width_p'(drop)
                     : (drop && !(&drop_count_q)) ? drop_count_q + 1'b1 : drop_count_q;
        overflow_d   = drop | (overflow_q & ~clear_i);
    end

    // Drop statistics registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign drop_count_o = drop_count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_vc_fwd_event_logger.sv
// tb_vc_fwd_event_logger: directed and random stimulus checked against a queue-based reference model

module tb_vc_fwd_event_logger;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int XW  = 4;
    localparam int YW  = 5;
    localparam int NX  = 4;
    localparam int NY  = 4;
    localparam int ELS = 8;
    localparam int DCW = 16;
    localparam int PW  = AW + DW + 2*XW + 2*YW;
    localparam int LW  = PW + 2;
    localparam int RW  = 32 + 2*XW + 2*YW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [LW-1:0] link_i, link_o;
    logic [31:0]   ctr;
    logic          en, clr, yumi;
    logic          v_o, ovf_o;
    logic [RW-1:0] data_o;
    logic [DCW-1:0] drop_o;

    logic          fv, frdy;
    logic [XW-1:0] sx, dx;
    logic [YW-1:0] sy, dy;
    logic [AW-1:0] addr;
    logic [DW-1:0] pdata;

    // Inbound side carries request; outbound side carries ready. Unused fields hold decoys.
    assign link_i = {fv, addr, pdata, sy, sx, dy, dx, ~frdy};
    assign link_o = {~fv, ~{addr, pdata, sy, sx, dy, dx}, frdy};

    logic [RW-1:0] q[$];
    int unsigned   m_drop;
    bit            m_ovf;
    int            checks = 0;
    int            fails  = 0;

    vc_fwd_event_logger #(
        .link_addr_width_p (AW),
        .data_width_p      (DW),
        .x_cord_width_p    (XW),
        .y_cord_width_p    (YW),
        .num_tiles_x_p     (NX),
        .num_tiles_y_p     (NY),
        .els_p             (ELS),
        .drop_ctr_width_p  (DCW)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .link_sif_i   (link_i),
        .link_sif_o   (link_o),
        .global_ctr_i (ctr),
        .en_i         (en),
        .clear_i      (clr),
        .v_o          (v_o),
        .data_o       (data_o),
        .yumi_i       (yumi),
        .drop_count_o (drop_o),
        .overflow_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_v"}, 64'(v_o), 64'(q.size() != 0));
        if (q.size() != 0) check({tag, "_data"}, 64'(data_o), 64'(q[0]));
        check({tag, "_drop"}, 64'(drop_o), 64'(m_drop));
        check({tag, "_ovf"}, 64'(ovf_o), 64'(m_ovf));
    endtask

    task automatic pkt(input bit v, input bit r, input int x, input int y, input int ddx, input int ddy, input int c);
        fv    = v;
        frdy  = r;
        sx    = XW'(x);
        sy    = YW'(y);
        dx    = XW'(ddx);
        dy    = YW'(ddy);
        ctr   = 32'(c);
        addr  = AW'($urandom);
        pdata = DW'($urandom);
    endtask

    // One clock: model applies the spec rules to the inputs held across the edge, then compares
    task automatic tick(input string tag);
        bit cap, dropped;
        logic [RW-1:0] rec;
        cap = en && fv && frdy && int'(sx) >= NX && int'(sx) < 2*NX && int'(sy) >= NY && int'(sy) < 2*NY;
        rec = {ctr, sx, sy, dx, dy};
        @(posedge clk);
        #1;
        if (yumi) void'(q.pop_front());
        dropped = 1'b0;
        if (cap) begin
            if (q.size() < ELS) q.push_back(rec);
            else dropped = 1'b1;
        end
        if (clr) begin
            m_drop = dropped ? 1 : 0;
            m_ovf  = dropped;
        end else if (dropped) begin
            if (m_drop != 32'hFFFF) m_drop++;
            m_ovf = 1'b1;
        end
        check_model(tag);
    endtask

    task automatic drain(input string tag);
        fv = 1'b0;
        while (q.size() != 0) begin
            yumi = 1'b1;
            tick(tag);
        end
        yumi = 1'b0;
    endtask

    initial begin
        int xs[5];
        int ys[5];
        reset_n = 1'b0;
        en = 1'b1; clr = 1'b0; yumi = 1'b0;
        pkt(0, 0, 0, 0, 0, 0, 0);
        m_drop = 0; m_ovf = 1'b0;
        #3;
        check("rst_v", 64'(v_o), 64'(0));
        check("rst_drop", 64'(drop_o), 64'(0));
        check("rst_ovf", 64'(ovf_o), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // Basic capture, one-cycle latency
        pkt(1, 1, 5, 6, 1, 9, 100);
        tick("t1");
        check("t1_record", 64'(data_o), 64'({32'd100, 4'd5, 5'd6, 4'd1, 5'd9}));
        drain("t1_drain");

        // Window boundaries
        xs = '{3, 8, 5, 4, 7};
        ys = '{5, 5, 8, 4, 7};
        for (int i = 0; i < 5; i++) begin
            pkt(1, 1, xs[i], ys[i], i, i + 2, int'($urandom));
            tick("t2");
        end
        drain("t2_drain");

        // Only the accepted beat of a stalled packet is logged
        for (int i = 0; i < 5; i++) begin
            pkt(1, 0, 5, 5, 2, 3, 200 + i);
            tick("t3_stall");
        end
        pkt(1, 1, 5, 5, 2, 3, 300);
        tick("t3_accept");
        fv = 1'b0;
        tick("t3_idle");
        check("t3_one_record", 64'(data_o), 64'({32'd300, 4'd5, 5'd5, 4'd2, 5'd3}));
        drain("t3_drain");

        // Overflow with stalled sink, then clear and drain
        for (int i = 0; i < 10; i++) begin
            pkt(1, 1, 4 + (i % 4), 4 + (i % 3), i, i, 1000 + i);
            tick("t4_fill");
        end
        check("t4_drop_count", 64'(drop_o), 64'(2));
        check("t4_overflow", 64'(ovf_o), 64'(1));
        fv = 1'b0; clr = 1'b1;
        tick("t4_clear");
        clr = 1'b0;
        check("t4_cleared", 64'({ovf_o, drop_o}), 64'(0));
        check("t4_head", 64'(data_o), 64'({32'd1000, 4'd4, 5'd4, 4'd0, 5'd0}));
        drain("t4_drain");

        // Full plus push plus pop, then wrap-around traffic
        for (int i = 0; i < ELS; i++) begin
            pkt(1, 1, 6, 5, 1, 1, 2000 + i);
            tick("t5_fill");
        end
        pkt(1, 1, 7, 6, 3, 3, 2100);
        yumi = 1'b1;
        tick("t5_full_pushpop");
        check("t5_no_drop", 64'(drop_o), 64'(0));
        for (int i = 0; i < 30; i++) begin
            pkt(1, 1, 4 + (i % 4), 7, i, i, 3000 + i);
            tick("t5_wrap");
        end
        check("t5_still_full", 64'(v_o), 64'(1));
        pkt(1, 1, 5, 5, 0, 0, 4000);
        yumi = 1'b0; clr = 1'b1;
        tick("t5_clear_drop");
        clr = 1'b0;
        check("t5_clear_drop_cnt", 64'({ovf_o, drop_o}), 64'({1'b1, 16'd1}));

        // Disabled capture still drains
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pkt(1, 1, 5, 5, 1, 1, 5000 + i);
            yumi = q.size() != 0;
            tick("t_en_off");
        end
        en = 1'b1;
        yumi = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            pkt(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                int'($urandom_range(2, 9)), int'($urandom_range(2, 9)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), int'($urandom));
            en   = $urandom_range(0, 7) != 0;
            clr  = $urandom_range(0, 19) == 0;
            yumi = (q.size() != 0) && ($urandom_range(0, 2) == 0);
            tick("rand");
        end
        en = 1'b1; clr = 1'b0;
        drain("rand_drain");

        // Async reset mid-cycle with records buffered and a drop recorded
        for (int i = 0; i < ELS + 1; i++) begin
            pkt(1, 1, 4, 6, 2, 2, 6000 + i);
            tick("t6_fill");
        end
        fv = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
        check("t6_rst_v", 64'(v_o), 64'(0));
        check("t6_rst_drop", 64'(drop_o), 64'(0));
        check("t6_rst_ovf", 64'(ovf_o), 64'(0));
        @(negedge clk) reset_n = 1'b1;
        pkt(1, 1, 7, 4, 5, 6, 7777);
        tick("t6_after");
        check("t6_record", 64'(data_o), 64'({32'd7777, 4'd7, 5'd4, 4'd5, 5'd6}));
        fv = 1'b0;
        drain("t6_drain");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
